// File: rtl/bp_be_scoreboard_pkg.sv
// Shared RV64 definitions: opcode map, instruction field layout and the
// register-usage record produced by the decoder.
package bp_be_scoreboard_pkg;

    localparam logic [6:0] rv64_opcode_op      = 7'b0110011;
    localparam logic [6:0] rv64_opcode_op32    = 7'b0111011;
    localparam logic [6:0] rv64_opcode_opimm   = 7'b0010011;
    localparam logic [6:0] rv64_opcode_opimm32 = 7'b0011011;
    localparam logic [6:0] rv64_opcode_load    = 7'b0000011;
    localparam logic [6:0] rv64_opcode_store   = 7'b0100011;
    localparam logic [6:0] rv64_opcode_branch  = 7'b1100011;
    localparam logic [6:0] rv64_opcode_jal     = 7'b1101111;
    localparam logic [6:0] rv64_opcode_jalr    = 7'b1100111;
    localparam logic [6:0] rv64_opcode_lui     = 7'b0110111;
    localparam logic [6:0] rv64_opcode_auipc   = 7'b0010111;
    localparam logic [6:0] rv64_opcode_amo     = 7'b0101111;
    localparam logic [6:0] rv64_opcode_system  = 7'b1110011;
    localparam logic [6:0] rv64_opcode_miscmem = 7'b0001111;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rv64_instr_s;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rs1_v;
        logic       rs2_v;
        logic       rd_v;
    } reg_decode_s;

endpackage

// File: rtl/bp_be_instr_reg_decode.sv
// Combinational register-usage decode of an RV64 instruction: which of
// rs1/rs2/rd the instruction actually reads or writes.
module bp_be_instr_reg_decode
    import bp_be_scoreboard_pkg::*;
(
    input  rv64_instr_s instr,
    output reg_decode_s decode
);

    always_comb begin
        decode       = '0;
        decode.rs1   = instr.rs1;
        decode.rs2   = instr.rs2;
        decode.rd    = instr.rd;
        case (instr.opcode)
            rv64_opcode_op, rv64_opcode_op32, rv64_opcode_amo: begin
                decode.rs1_v = 1'b1;
                decode.rs2_v = 1'b1;
                decode.rd_v  = 1'b1;
            end
            rv64_opcode_opimm, rv64_opcode_opimm32, rv64_opcode_load,
            rv64_opcode_jalr, rv64_opcode_system: begin
                decode.rs1_v = 1'b1;
                decode.rd_v  = 1'b1;
            end
            rv64_opcode_store, rv64_opcode_branch: begin
                decode.rs1_v = 1'b1;
                decode.rs2_v = 1'b1;
            end
            rv64_opcode_lui, rv64_opcode_auipc, rv64_opcode_jal: begin
                decode.rd_v  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bp_be_scoreboard.sv
// Busy-register scoreboard: holds issue on RAW/WAW hazards against pending
// long-latency writes and on a full pending-write budget.
module bp_be_scoreboard
    import bp_be_scoreboard_pkg::*;
#(
    parameter  int wb_ports_p    = 2,
    parameter  int max_pending_p = 4,
    localparam int cnt_w         = $clog2(max_pending_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    flush_i,
    input  logic                    issue_v_i,
    input  logic [31:0]             issue_instr_i,
    input  logic                    issue_long_i,
    output logic                    issue_ready_o,
    input  logic [wb_ports_p-1:0]   wb_v_i,
    input  logic [5*wb_ports_p-1:0] wb_rd_addr_i,
    output logic [31:0]             busy_o,
    output logic [cnt_w-1:0]        pending_count_o
);

    logic [31:0]      busy_reg, busy_next;
    logic [cnt_w-1:0] count_reg, count_next;

    rv64_instr_s instr;
    reg_decode_s dec;

    assign instr = rv64_instr_s'(issue_instr_i);

    bp_be_instr_reg_decode u_decode (
        .instr  (instr),
        .decode (dec)
    );

    // Ready depends only on registered state, so a same-cycle writeback never
    // releases a stalled instruction early.
    logic rs1_haz, rs2_haz, rd_haz, full_haz, rd_nonzero, set_v;

    assign rd_nonzero = (dec.rd != 5'd0);
    assign rs1_haz    = dec.rs1_v && (dec.rs1 != 5'd0) && busy_reg[dec.rs1];
    assign rs2_haz    = dec.rs2_v && (dec.rs2 != 5'd0) && busy_reg[dec.rs2];
    assign rd_haz     = dec.rd_v && rd_nonzero && busy_reg[dec.rd];
    assign full_haz   = issue_long_i && dec.rd_v && rd_nonzero
                        && (count_reg == cnt_w'(max_pending_p));

    assign issue_ready_o = !(rs1_haz || rs2_haz || rd_haz || full_haz) && !flush_i;
    assign set_v         = issue_v_i && issue_ready_o && issue_long_i
                           && dec.rd_v && rd_nonzero;

    logic [wb_ports_p-1:0] clr_hit;
    logic [31:0]           clr_mask [wb_ports_p];

    generate
        for (genvar gi = 0; gi < wb_ports_p; gi++) begin : g_wb
            logic [4:0] addr;
            assign addr         = wb_rd_addr_i[gi*5 +: 5];
            assign clr_hit[gi]  = wb_v_i[gi] && (addr != 5'd0) && busy_reg[addr];
            assign clr_mask[gi] = clr_hit[gi] ? (32'd1 << addr) : 32'd0;
        end
    endgenerate

    logic [31:0]      clr_all;
    logic [cnt_w-1:0] clr_cnt;

    always_comb begin
        clr_all = 32'd0;
        clr_cnt = '0;
        for (int i = 0; i < wb_ports_p; i++) begin
            clr_all = clr_all | clr_mask[i];
            clr_cnt = clr_cnt + cnt_w'(clr_hit[i]);
        end
        busy_next    = (busy_reg & ~clr_all) | (32'(set_v) << dec.rd);
        busy_next[0] = 1'b0;
        count_next   = count_reg + cnt_w'(set_v) - clr_cnt;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_reg  <= 32'd0;
            count_reg <= '0;
        end else if (flush_i) begin
            busy_reg  <= 32'd0;
            count_reg <= '0;
        end else begin
            busy_reg  <= busy_next;
            count_reg <= count_next;
        end
    end

    assign busy_o          = busy_reg;
    assign pending_count_o = count_reg;

endmodule

// File: tb/tb_bp_be_scoreboard.sv
// Directed bench for bp_be_scoreboard: inputs change just after the falling
// edge, outputs are sampled 1ns later, well away from the rising edge.
`timescale 1ns/1ps
module tb_bp_be_scoreboard;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        issue_v_i = 1'b0;
    logic [31:0] issue_instr_i = 32'd0;
    logic        issue_long_i = 1'b0;
    logic        issue_ready_o;
    logic [1:0]  wb_v_i = 2'b00;
    logic [9:0]  wb_rd_addr_i = 10'd0;
    logic [31:0] busy_o;
    logic [2:0]  pending_count_o;

    int checks = 0;
    int passes = 0;

    always #5 clk_i = ~clk_i;

    bp_be_scoreboard #(.wb_ports_p(2), .max_pending_p(4)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .flush_i         (flush_i),
        .issue_v_i       (issue_v_i),
        .issue_instr_i   (issue_instr_i),
        .issue_long_i    (issue_long_i),
        .issue_ready_o   (issue_ready_o),
        .wb_v_i          (wb_v_i),
        .wb_rd_addr_i    (wb_rd_addr_i),
        .busy_o          (busy_o),
        .pending_count_o (pending_count_o)
    );

    always @(posedge clk_i) begin
        assert (!(wb_v_i == 2'b11 && wb_rd_addr_i[4:0] == wb_rd_addr_i[9:5]))
            else $error("illegal: both writeback ports name the same register");
    end

    function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b011, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [6:0] op, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b011, 5'd0, op};
    endfunction

    task automatic present(input logic v, input logic lng, input logic [31:0] ins);
        issue_v_i     = v;
        issue_long_i  = lng;
        issue_instr_i = ins;
        if (v) $display("t=%0t issue instr=%h long=%0d", $time, ins, lng);
    endtask

    task automatic wb(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1);
        wb_v_i       = v;
        wb_rd_addr_i = {a1, a0};
        if (v != 2'b00) $display("t=%0t writeback v=%b a0=x%0d a1=x%0d", $time, v, a0, a1);
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        #1;
        checks++; if (busy_o !== 32'd0) $display("FAIL reset_busy got=%h exp=0", busy_o); else passes++;
        checks++; if (pending_count_o !== 3'd0) $display("FAIL reset_count got=%0d exp=0", pending_count_o); else passes++;
        reset_i = 1'b0;
        @(negedge clk_i);
        present(1'b1, 1'b0, enc_r(OP_OP, 5'd3, 5'd1, 5'd2));
        #1;
        checks++; if (issue_ready_o !== 1'b1) $display("FAIL reset_add_ready got=%b exp=1", issue_ready_o); else passes++;
        @(negedge clk_i);
        present(1'b0, 1'b0, 32'd0);
        #1;
        checks++; if (busy_o !== 32'd0) $display("FAIL short_no_busy got=%h exp=0", busy_o); else passes++;
        checks++; if (pending_count_o !== 3'd0) $display("FAIL short_no_count got=%0d exp=0", pending_count_o); else passes++;
    endtask

    task automatic test_raw();
        @(negedge clk_i);
        present(1'b1, 1'b1, enc_i(OP_LOAD, 5'd5, 5'd10, 12'd0));
        #1;
        checks++; if (issue_ready_o !== 1'b1) $display("FAIL raw_ld_ready got=%b exp=1", issue_ready_o); else passes++;
        @(negedge clk_i);
        present(1'b1, 1'b0, enc_r(OP_OP, 5'd6, 5'd5, 5'd1));
        #1;
        checks++; if (issue_ready_o !== 1'b0) $display("FAIL raw_stall_t1 got=%b exp=0", issue_ready_o); else passes++;
        checks++; if (busy_o !== 32'h20) $display("FAIL raw_busy got=%h exp=20", busy_o); else passes++;
        checks++; if (pending_count_o !== 3'd1) $display("FAIL raw_count got=%0d exp=1", pending_count_o); else passes++;
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk_i);
            #1;
            checks++; if (issue_ready_o !== 1'b0) $display("FAIL raw_stall_t%0d got=%b exp=0", c, issue_ready_o); else passes++;
        end
        @(negedge clk_i);
        wb(2'b01, 5'd5, 5'd0);
        #1;
        checks++; if (issue_ready_o !== 1'b0) $display("FAIL raw_no_bypass got=%b exp=0", issue_ready_o); else passes++;
        @(negedge clk_i);
        wb(2'b00, 5'd0, 5'd0);
        #1;
        checks++; if (issue_ready_o !== 1'b1) $display("FAIL raw_release got=%b exp=1", issue_ready_o); else passes++;
        checks++; if (busy_o !== 32'd0) $display("FAIL raw_cleared got=%h exp=0", busy_o); else passes++;
        checks++; if (pending_count_o !== 3'd0) $display("FAIL raw_count0 got=%0d exp=0", pending_count_o); else passes++;
        @(negedge clk_i);
        present(1'b0, 1'b0, 32'd0);
    endtask

    task automatic test_waw();
        @(negedge clk_i);
        present(1'b1, 1'b1, enc_i(OP_LOAD, 5'd7, 5'd10, 12'd8));
        #1;
        checks++; if (issue_ready_o !== 1'b1) $display("FAIL waw_ld_ready got=%b exp=1", issue_ready_o); else passes++;
        @(negedge clk_i);
        present(1'b1, 1'b0, enc_i(OP_OPIMM, 5'd7, 5'd0, 12'd1));
        #1;
        checks++; if (issue_ready_o !== 1'b0) $display("FAIL waw_addi_stall got=%b exp=0", issue_ready_o); else passes++;
        checks++; if (busy_o !== 32'h80) $display("FAIL waw_busy got=%h exp=80", busy_o); else passes++;
        @(negedge clk_i);
        present(1'b1, 1'b0, enc_s(OP_STORE, 5'd10, 5'd7));
        #1;
        checks++; if (issue_ready_o !== 1'b0) $display("FAIL waw_sw_rs2_stall got=%b exp=0", issue_ready_o); else passes++;
        @(negedge clk_i);
        present(1'b1, 1'b0, enc_i(OP_OPIMM, 5'd8, 5'd0, 12'd1));
        #1;
        checks++; if (issue_ready_o !== 1'b1) $display("FAIL waw_unrelated_ready got=%b exp=1", issue_ready_o); else passes++;
        @(negedge clk_i);
        present(1'b0, 1'b0, 32'd0);
        wb(2'b10, 5'd0, 5'd7);
        @(negedge clk_i);
        wb(2'b00, 5'd0, 5'd0);
        present(1'b1, 1'b1, enc_i(OP_LOAD, 5'd0, 5'd10, 12'd0));
        #1;
        checks++; if (busy_o !== 32'd0) $display("FAIL waw_cleared got=%h exp=0", busy_o); else passes++;
        checks++; if (issue_ready_o !== 1'b1) $display("FAIL x0_long_ready got=%b exp=1", issue_ready_o); else passes++;
        @(negedge clk_i);
        present(1'b0, 1'b0, 32'd0);
        #1;
        checks++; if (pending_count_o !== 3'd0) $display("FAIL x0_long_count got=%0d exp=0", pending_count_o); else passes++;
        checks++; if (busy_o !== 32'd0) $display("FAIL x0_long_busy got=%h exp=0", busy_o); else passes++;
    endtask

    task automatic test_saturation();
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk_i);
            present(1'b1, 1'b1, enc_i(OP_LOAD, 5'(r), 5'd10, 12'd0));
            #1;
            checks++; if (issue_ready_o !== 1'b1) $display("FAIL sat_fill_x%0d got=%b exp=1", r, issue_ready_o); else passes++;
        end
        @(negedge clk_i);
        present(1'b1, 1'b1, enc_i(OP_LOAD, 5'd8, 5'd10, 12'd0));
        #1;
        checks++; if (pending_count_o !== 3'd4) $display("FAIL sat_count got=%0d exp=4", pending_count_o); else passes++;
        checks++; if (busy_o !== 32'h1E) $display("FAIL sat_busy got=%h exp=1e", busy_o); else passes++;
        checks++; if (issue_ready_o !== 1'b0) $display("FAIL sat_fifth_stall got=%b exp=0", issue_ready_o); else passes++;
        @(negedge clk_i);
        present(1'b1, 1'b0, enc_i(OP_OPIMM, 5'd9, 5'd0, 12'd1));
        #1;
        checks++; if (issue_ready_o !== 1'b1) $display("FAIL sat_short_ready got=%b exp=1", issue_ready_o); else passes++;
        @(negedge clk_i);
        present(1'b1, 1'b1, enc_i(OP_LOAD, 5'd8, 5'd10, 12'd0));
        wb(2'b01, 5'd2, 5'd0);
        #1;
        checks++; if (issue_ready_o !== 1'b0) $display("FAIL sat_wb_same_cycle got=%b exp=0", issue_ready_o); else passes++;
        @(negedge clk_i);
        wb(2'b00, 5'd0, 5'd0);
        #1;
        checks++; if (issue_ready_o !== 1'b1) $display("FAIL sat_fifth_accept got=%b exp=1", issue_ready_o); else passes++;
        checks++; if (pending_count_o !== 3'd3) $display("FAIL sat_count_after_wb got=%0d exp=3", pending_count_o); else passes++;
        @(negedge clk_i);
        present(1'b0, 1'b0, 32'd0);
        #1;
        checks++; if (pending_count_o !== 3'd4) $display("FAIL sat_count_refill got=%0d exp=4", pending_count_o); else passes++;
        checks++; if (busy_o !== 32'h11A) $display("FAIL sat_busy_refill got=%h exp=11a", busy_o); else passes++;
    endtask

    task automatic test_dual_wb();
        @(negedge clk_i);
        wb(2'b01, 5'd8, 5'd0);
        @(negedge clk_i);
        wb(2'b11, 5'd1, 5'd3);
        #1;
        checks++; if (pending_count_o !== 3'd3) $display("FAIL dual_pre_count got=%0d exp=3", pending_count_o); else passes++;
        @(negedge clk_i);
        wb(2'b10, 5'd0, 5'd12);
        #1;
        checks++; if (pending_count_o !== 3'd1) $display("FAIL dual_count got=%0d exp=1", pending_count_o); else passes++;
        checks++; if (busy_o !== 32'h10) $display("FAIL dual_busy got=%h exp=10", busy_o); else passes++;
        @(negedge clk_i);
        wb(2'b00, 5'd0, 5'd0);
        #1;
        checks++; if (pending_count_o !== 3'd1) $display("FAIL nonbusy_wb_count got=%0d exp=1", pending_count_o); else passes++;
        checks++; if (busy_o !== 32'h10) $display("FAIL nonbusy_wb_busy got=%h exp=10", busy_o); else passes++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk_i);
        present(1'b1, 1'b1, enc_i(OP_LOAD, 5'd12, 5'd10, 12'd0));
        wb(2'b01, 5'd4, 5'd0);
        #1;
        checks++; if (issue_ready_o !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", issue_ready_o); else passes++;
        @(negedge clk_i);
        present(1'b0, 1'b0, 32'd0);
        wb(2'b01, 5'd12, 5'd0);
        #1;
        checks++; if (pending_count_o !== 3'd1) $display("FAIL b2b_net_count got=%0d exp=1", pending_count_o); else passes++;
        checks++; if (busy_o !== 32'h1000) $display("FAIL b2b_busy got=%h exp=1000", busy_o); else passes++;
        @(negedge clk_i);
        wb(2'b00, 5'd0, 5'd0);
        #1;
        checks++; if (pending_count_o !== 3'd0) $display("FAIL b2b_drain got=%0d exp=0", pending_count_o); else passes++;
    endtask

    task automatic test_flush_reset();
        @(negedge clk_i);
        present(1'b1, 1'b1, enc_i(OP_LOAD, 5'd5, 5'd10, 12'd0));
        @(negedge clk_i);
        present(1'b1, 1'b1, enc_i(OP_LOAD, 5'd6, 5'd10, 12'd0));
        flush_i = 1'b1;
        #1;
        checks++; if (issue_ready_o !== 1'b0) $display("FAIL flush_ready got=%b exp=0", issue_ready_o); else passes++;
        checks++; if (busy_o !== 32'h20) $display("FAIL flush_pre_busy got=%h exp=20", busy_o); else passes++;
        @(negedge clk_i);
        flush_i = 1'b0;
        present(1'b0, 1'b0, 32'd0);
        #1;
        checks++; if (busy_o !== 32'd0) $display("FAIL flush_busy got=%h exp=0", busy_o); else passes++;
        checks++; if (pending_count_o !== 3'd0) $display("FAIL flush_count got=%0d exp=0", pending_count_o); else passes++;
        @(negedge clk_i);
        present(1'b1, 1'b1, enc_i(OP_LOAD, 5'd5, 5'd10, 12'd0));
        @(negedge clk_i);
        present(1'b0, 1'b1, enc_r(OP_OP, 5'd6, 5'd5, 5'd1));
        #1;
        checks++; if (busy_o !== 32'h20) $display("FAIL areset_pre_busy got=%h exp=20", busy_o); else passes++;
        checks++; if (issue_ready_o !== 1'b0) $display("FAIL areset_pre_ready got=%b exp=0", issue_ready_o); else passes++;
        reset_i = 1'b1;
        $display("t=%0t async reset asserted", $time);
        #1;
        checks++; if (busy_o !== 32'd0) $display("FAIL areset_busy got=%h exp=0", busy_o); else passes++;
        checks++; if (pending_count_o !== 3'd0) $display("FAIL areset_count got=%0d exp=0", pending_count_o); else passes++;
        checks++; if (issue_ready_o !== 1'b1) $display("FAIL areset_ready got=%b exp=1", issue_ready_o); else passes++;
        #1;
        reset_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_raw();
        test_waw();
        test_saturation();
        test_dual_wb();
        test_back_to_back();
        test_flush_reset();
        repeat (2) @(negedge clk_i);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
